// File: rtl/gpr_file_mp_if.sv
// Port bundle for gpr_file_mp: read ports, two write-back ports, issue marks and init sweep.
// Enables are single-cycle qualifiers with no back-pressure: a write, issue or init_req takes effect at the edge where it is high.
interface gpr_file_mp_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
);
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_busy;

    logic                       wr0_en;
    logic [ADDR_W-1:0]          wr0_addr;
    logic [DATA_W-1:0]          wr0_data;
    logic                       wr1_en;
    logic [ADDR_W-1:0]          wr1_addr;
    logic [DATA_W-1:0]          wr1_data;

    logic                       issue_en;
    logic [ADDR_W-1:0]          issue_addr;

    logic                       init_req;
    logic                       init_busy;
    logic                       wr_conflict;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               issue_en, issue_addr, init_req,
        input  rd_data, rd_busy, init_busy, wr_conflict
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               issue_en, issue_addr, init_req,
        output rd_data, rd_busy, init_busy, wr_conflict
    );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: bypassed reads, two prioritised write-back ports,
// per-register pending scoreboard and a sequential zero-initialisation sweep.
module gpr_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gpr_file_mp_if.slave  bus,
    output logic          state_dbg
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NREGS - 1);
    localparam bit              ZR       = (ZERO_REG != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    logic              conf_q, conf_d;

    logic              idle;
    logic              w0, w1, iss;
    logic [ADDR_W-1:0] sweep_idx;

    assign idle      = (state_q == S_IDLE);
    assign sweep_idx = cnt_q[ADDR_W-1:0];

    // Effective enables: everything external is ignored while sweeping,
    // and register 0 is untouchable when it is hard-wired to zero.
    assign w0  = idle && bus.wr0_en   && !(ZR && (bus.wr0_addr   == '0));
    assign w1  = idle && bus.wr1_en   && !(ZR && (bus.wr1_addr   == '0));
    assign iss = idle && bus.issue_en && !(ZR && (bus.issue_addr == '0));

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.init_req) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                end
            end
            S_SWEEP: begin
                // Counter ends at NREGS after the last write and holds there.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.init_busy = (state_q == S_SWEEP);
    assign state_dbg     = (state_q == S_SWEEP);

    // ------------------------------------------------------------------
    // Register array; wr1 is written last so it wins on an address tie
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (!idle) begin
            regs_q[sweep_idx] <= '0;
        end else begin
            if (w0) regs_q[bus.wr0_addr] <= bus.wr0_data;
            if (w1) regs_q[bus.wr1_addr] <= bus.wr1_data;
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard and conflict pulse
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        if (!idle) begin
            pend_d[sweep_idx] = 1'b0;
        end else begin
            if (w0)  pend_d[bus.wr0_addr]   = 1'b0;
            if (w1)  pend_d[bus.wr1_addr]   = 1'b0;
            // Issue applied last: a new producer overrides a retiring one.
            if (iss) pend_d[bus.issue_addr] = 1'b1;
        end
        if (ZR) pend_d[0] = 1'b0;
    end

    assign conf_d = w0 && w1 && (bus.wr0_addr == bus.wr1_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            conf_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            conf_q <= conf_d;
        end
    end

    assign bus.wr_conflict = conf_q;

    // ------------------------------------------------------------------
    // Bypassed read ports
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        hit0        = 1'b0;
        hit1        = 1'b0;
        for (int k = 0; k < RD_PORTS; k++) begin
            ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
            // w0/w1 are already gated off during the sweep, disabling bypass.
            hit0 = w0 && (bus.wr0_addr == ra);
            hit1 = w1 && (bus.wr1_addr == ra);
            if (ZR && (ra == '0)) begin
                bus.rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (hit1) begin
                bus.rd_data[k*DATA_W +: DATA_W] = bus.wr1_data;
            end else if (hit0) begin
                bus.rd_data[k*DATA_W +: DATA_W] = bus.wr0_data;
            end else begin
                bus.rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
            end
            bus.rd_busy[k] = pend_q[ra] && !hit0 && !hit1 && !(ZR && (ra == '0));
        end
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed self-checking bench for gpr_file_mp (32 x 32-bit, 2 read ports, ZERO_REG=1).
module tb_gpr_file_mp;
    localparam int DATA_W   = 32;
    localparam int NREGS    = 32;
    localparam int ADDR_W   = 5;
    localparam int RD_PORTS = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_v;
    int busy_cycles;
    int conf_cycles;

    gpr_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)) bus ();

    gpr_file_mp #(
        .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
        .RD_PORTS(RD_PORTS), .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr0_en     = 1'b0;
        bus.wr0_addr   = '0;
        bus.wr0_data   = '0;
        bus.wr1_en     = 1'b0;
        bus.wr1_addr   = '0;
        bus.wr1_data   = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.init_req   = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        bus.rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int k);
        return bus.rd_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rb(input int k);
        return {{(DATA_W-1){1'b0}}, bus.rd_busy[k]};
    endfunction

    function automatic logic [DATA_W-1:0] fill_val(input int i);
        return 32'hA500_0000 | (i * 32'h0000_0101);
    endfunction

    task automatic write0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr0_en   = 1'b1;
        bus.wr0_addr = a;
        bus.wr0_data = d;
        tick();
        bus.wr0_en   = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.issue_en   = 1'b1;
        bus.issue_addr = a;
        tick();
        bus.issue_en   = 1'b0;
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        clear_inputs();
        bus.rd_addr = '0;
        set_rd(0, 5);
        set_rd(1, 9);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd0",   rd(0), 32'h0);
        check("rst_busy0", rb(0), 32'h0);
        check("rst_ibusy", {31'b0, bus.init_busy}, 32'h0);
        check("rst_conf",  {31'b0, bus.wr_conflict}, 32'h0);
        check("rst_state", {31'b0, state_dbg}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write reg 5: bypass in same cycle, array next cycle
        bus.wr0_en = 1'b1; bus.wr0_addr = 5; bus.wr0_data = 32'hDEAD_BEEF;
        #1;
        check("wr_bypass", rd(0), 32'hDEAD_BEEF);
        tick();
        bus.wr0_en = 1'b0;
        #1;
        check("wr_array", rd(0), 32'hDEAD_BEEF);
        check("wr_noconf", {31'b0, bus.wr_conflict}, 32'h0);

        // Same-address write on both ports: wr1 wins, conflict pulses once
        set_rd(0, 7); set_rd(1, 7);
        bus.wr0_en = 1'b1; bus.wr0_addr = 7; bus.wr0_data = 32'h1111;
        bus.wr1_en = 1'b1; bus.wr1_addr = 7; bus.wr1_data = 32'h2222;
        #1;
        check("conf_bypass0", rd(0), 32'h2222);
        check("conf_bypass1", rd(1), 32'h2222);
        check("conf_pre", {31'b0, bus.wr_conflict}, 32'h0);
        tick();
        clear_inputs();
        #1;
        check("conf_array", rd(0), 32'h2222);
        check("conf_pulse", {31'b0, bus.wr_conflict}, 32'h1);
        tick();
        check("conf_end", {31'b0, bus.wr_conflict}, 32'h0);

        // Different addresses on the two ports: both written, no conflict
        set_rd(0, 3); set_rd(1, 4);
        bus.wr0_en = 1'b1; bus.wr0_addr = 3; bus.wr0_data = 32'h0303;
        bus.wr1_en = 1'b1; bus.wr1_addr = 4; bus.wr1_data = 32'h0404;
        tick();
        clear_inputs();
        #1;
        check("dual_rd0", rd(0), 32'h0303);
        check("dual_rd1", rd(1), 32'h0404);
        check("dual_noconf", {31'b0, bus.wr_conflict}, 32'h0);

        // Scoreboard on reg 9
        set_rd(0, 9);
        bus.issue_en = 1'b1; bus.issue_addr = 9;
        #1;
        check("iss_lat0", rb(0), 32'h0);
        tick();
        bus.issue_en = 1'b0;
        #1;
        check("iss_busy", rb(0), 32'h1);
        bus.wr0_en = 1'b1; bus.wr0_addr = 9; bus.wr0_data = 32'h0ABC;
        #1;
        check("wb_busy_byp", rb(0), 32'h0);
        check("wb_data_byp", rd(0), 32'h0ABC);
        tick();
        bus.wr0_en = 1'b0;
        #1;
        check("wb_cleared", rb(0), 32'h0);
        issue(9);
        check("reiss_busy", rb(0), 32'h1);
        bus.issue_en = 1'b1; bus.issue_addr = 9;
        bus.wr1_en = 1'b1; bus.wr1_addr = 9; bus.wr1_data = 32'h0055;
        tick();
        clear_inputs();
        #1;
        check("iss_wins", rb(0), 32'h1);
        check("iss_wins_data", rd(0), 32'h0055);
        write0(9, 32'h0056);
        check("iss_clr2", rb(0), 32'h0);

        // Register 0 is hard-wired
        set_rd(0, 0); set_rd(1, 0);
        bus.wr0_en = 1'b1; bus.wr0_addr = 0; bus.wr0_data = 32'hFFFF;
        bus.wr1_en = 1'b1; bus.wr1_addr = 0; bus.wr1_data = 32'hFFFF;
        bus.issue_en = 1'b1; bus.issue_addr = 0;
        #1;
        check("z_rd_byp", rd(0), 32'h0);
        check("z_busy_byp", rb(1), 32'h0);
        tick();
        clear_inputs();
        #1;
        check("z_rd", rd(0), 32'h0);
        check("z_busy", rb(0), 32'h0);
        check("z_noconf", {31'b0, bus.wr_conflict}, 32'h0);

        // Fill all regs, then sweep
        for (int i = 1; i < NREGS; i++) begin
            write0(ADDR_W'(i), fill_val(i));
        end
        issue(20);
        set_rd(0, 12); set_rd(1, 20);
        #1;
        check("fill_rd12", rd(0), fill_val(12));
        check("fill_busy20", rb(1), 32'h1);
        bus.init_req = 1'b1;
        #1;
        check("ibusy_pre", {31'b0, bus.init_busy}, 32'h0);
        busy_cycles = 0;
        conf_cycles = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (bus.init_busy)   busy_cycles++;
            if (bus.wr_conflict) conf_cycles++;
            if (j == 0) begin
                bus.wr0_en = 1'b1; bus.wr0_addr = 25; bus.wr0_data = 32'h0999;
                bus.wr1_en = 1'b1; bus.wr1_addr = 25; bus.wr1_data = 32'h0888;
                bus.issue_en = 1'b1; bus.issue_addr = 13;
                set_rd(0, 25); set_rd(1, 13);
                #1;
                check("sweep_nobyp", rd(0), fill_val(25));
                check("sweep_nobusy_byp", rb(1), 32'h0);
            end
            if (j == 3) clear_inputs();
        end
        check("sweep_len", busy_cycles, 32);
        check("sweep_noconf", conf_cycles, 0);
        check("sweep_state", {31'b0, state_dbg}, 32'h0);
        for (int i = 0; i < NREGS; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < NREGS; i++) begin
            set_rd(0, ADDR_W'(i));
            set_rd(1, ADDR_W'(i));
            #1;
            exp_v = exp_q.pop_front();
            check("sweep_rd0", rd(0), exp_v);
            check("sweep_rd1", rd(1), exp_v);
            check("sweep_pend", rb(0), 32'h0);
        end

        // Reset in the middle of a sweep
        write0(3, 32'h0033);
        write0(30, 32'h3030);
        issue(31);
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        repeat (10) tick();
        set_rd(0, 30); set_rd(1, 31);
        #1;
        check("mid_sweep_ibusy", {31'b0, bus.init_busy}, 32'h1);
        check("mid_sweep_rd30", rd(0), 32'h3030);
        check("mid_sweep_busy31", rb(1), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_ibusy", {31'b0, bus.init_busy}, 32'h0);
        check("arst_state", {31'b0, state_dbg}, 32'h0);
        check("arst_rd30", rd(0), 32'h0);
        check("arst_busy31", rb(1), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_ibusy", {31'b0, bus.init_busy}, 32'h0);
        set_rd(1, 3);
        #1;
        check("rel_rd30", rd(0), 32'h0);
        check("rel_rd3", rd(1), 32'h0);
        write0(30, 32'hCAFE);
        check("rel_write", rd(0), 32'hCAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
